pipeline_stall_ctrl: RTL and testbench
======================================

Name: pipeline_stall_ctrl

Overview:
- Sequencing controller for the 5-stage (F/D/E/M/W) pipeline.
- Generates per-stage stall and flush enables for the pipeline registers.
- Covers load-use bubbles, taken-branch flushes, the multi-cycle execute handshake and memory wait states.
- Sits beside the forwarding unit. Forwarding resolves the data hazards that need no stall; this block resolves everything that needs one.

Parameters:
REG_ADDR_W, 4, register address width
MEM_TIMEOUT, 255, MEM_WAIT cycles before MemTimeout is raised (1..2^16-1)
EX_MAX_CYC, 32, maximum cycles expected for a multi-cycle execute op (sizes the busy counter)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
Rs1D  in  REG_ADDR_W  source 1 of the instruction in Decode
Rs2D  in  REG_ADDR_W  source 2 of the instruction in Decode
RdE  in  REG_ADDR_W  destination of the instruction in Execute
MemReadE  in  1  instruction in E is a load
RegWriteE  in  1  instruction in E writes a register
PCSrcE  in  1  taken branch/jump resolved in E
MultiStartE  in  1  E holds a multi-cycle op; start pulse
MultiDoneE  in  1  multi-cycle unit result valid
MemReqM  in  1  M stage is issuing a memory access
MemReadyM  in  1  memory completes the access this cycle
StallF, StallD, StallE, StallM  out  1 each  hold the pipeline register
FlushD, FlushE, FlushM, FlushW  out  1 each  insert a bubble
MemTimeout  out  1  sticky wait-timeout error
PerfStallCnt  out  32  stall-cycle counter (optional feature)
PerfFlushCnt  out  32  flush-event counter (optional feature)

Behaviour:
- Reset: one clock; rst is asynchronous and active-high. Reset forces state RUN, clears all counters and MemTimeout, and drives every output to 0.
- Outputs: combinational from the current state plus current inputs, so a stall takes effect in the same cycle the condition is detected.
- States: RUN, MEM_WAIT, EX_BUSY.
- MEM_WAIT has priority 1 (highest):
  - Entered when MemReqM=1 and MemReadyM=0.
  - While waiting: StallF/D/E/M=1, FlushW=1.
  - Exits to RUN in the cycle MemReadyM=1. That cycle has no stall.
- EX_BUSY has priority 2:
  - Entered from RUN when MultiStartE=1.
  - While busy: StallF/D/E=1, FlushM=1.
  - Exits to RUN in the cycle MultiDoneE=1. That cycle has no stall.
  - If a memory wait arises while busy, MEM_WAIT behaviour overrides for that cycle. The state stays EX_BUSY until done.
- Branch flush has priority 3 and applies in RUN only:
  - PCSrcE=1 gives FlushD=1 and FlushE=1 for one cycle.
  - A branch held during a stall is applied on the first unstalled cycle.
- Load-use has priority 4 and applies in RUN only:
  - Condition: MemReadE & RegWriteE & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
  - Response: StallF=1, StallD=1, FlushE=1 for exactly one cycle.
  - Branch and load-use in the same cycle: the branch wins, with no stall.
- Timeout:
  - A 16-bit counter increments each MEM_WAIT cycle and clears on leaving MEM_WAIT.
  - When it reaches MEM_TIMEOUT, MemTimeout sets and stays set until rst. The counter saturates.
  - Waiting continues after the timeout.
- MultiDoneE arriving in the same cycle as MultiStartE: zero-cycle op, remain in RUN.
- MultiDoneE outside EX_BUSY is ignored.
- Reset mid-wait or mid-busy: immediate return to RUN. Stalls drop asynchronously.

Optional Feature:
- Macro: PIPELINE_STALL_PERF_EN.
- Defined:
  - PerfStallCnt increments on every cycle with StallF=1.
  - PerfFlushCnt increments on every cycle with FlushD|FlushE.
  - Both wrap at 2^32 and clear on rst.
- Undefined: both ports are tied to 0 and no counter flops are built.

Decomposition:
- Shared package (pipeline_pkg) holds:
  - ctrl_state_t enum {RUN, MEM_WAIT, EX_BUSY}
  - REG_ADDR_W default
  - the zero-register constant
- Sub-module: load_use_detect. It is the combinational comparator and outputs a single hazard bit.
- The FSM, counters and output priority mux stay in pipeline_stall_ctrl.

Test Plan:
- Load-use: MemReadE=1, RegWriteE=1, RdE=3, Rs1D=3 → one cycle of StallF=StallD=FlushE=1, then all 0. Repeat with RdE=0 → no stall.
- Branch vs load-use: PCSrcE=1 together with the load-use condition of the previous line → FlushD=FlushE=1, StallF=0.
- Memory wait: MemReqM=1, MemReadyM=0 for 4 cycles, then 1 → StallF..M=1 and FlushW=1 for 4 cycles, then 0. MEM_TIMEOUT=3 → MemTimeout rises on the 3rd wait cycle and stays 1 afterwards.
- Multi-cycle op: MultiStartE pulse, MultiDoneE 5 cycles later → StallF/D/E=1 and FlushM=1 for 5 cycles. A memory wait injected mid-op adds StallM and FlushW for those cycles only.
- Reset mid-operation: assert rst asynchronously in EX_BUSY → all outputs 0 within the same cycle; after release, state is RUN and MemTimeout=0.
- PIPELINE_STALL_PERF_EN: after the scenarios above, PerfStallCnt equals the count of StallF cycles and PerfFlushCnt equals the count of flush cycles. Without the macro, both read 0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline sequencing logic.
package pipeline_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    EX_BUSY  = 2'd2
  } ctrl_state_t;

  localparam int DEF_REG_ADDR_W = 4;

  // Architectural zero register: writes to it never create a hazard.
  localparam int ZERO_REG = 0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard comparator: flags a load in Execute whose destination
// is a source of the instruction currently in Decode.
module load_use_detect
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] i_rs1_d,
  input  logic [REG_ADDR_W-1:0] i_rs2_d,
  input  logic [REG_ADDR_W-1:0] i_rd_e,
  input  logic                  i_mem_read_e,
  input  logic                  i_reg_write_e,
  output logic                  o_hazard
);

  logic w_rd_nonzero;
  logic w_src_match;

  assign w_rd_nonzero = (i_rd_e != REG_ADDR_W'(ZERO_REG));
  assign w_src_match  = (i_rd_e == i_rs1_d) | (i_rd_e == i_rs2_d);
  assign o_hazard     = i_mem_read_e & i_reg_write_e & w_rd_nonzero & w_src_match;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage F/D/E/M/W pipeline.
// Optional build macro: PIPELINE_STALL_PERF_EN (stall/flush perf counters).
module pipeline_stall_ctrl
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_W  = DEF_REG_ADDR_W,
  parameter int MEM_TIMEOUT = 255,
  parameter int EX_MAX_CYC  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic [REG_ADDR_W-1:0] RdE,
  input  logic                  MemReadE,
  input  logic                  RegWriteE,
  input  logic                  PCSrcE,
  input  logic                  MultiStartE,
  input  logic                  MultiDoneE,
  input  logic                  MemReqM,
  input  logic                  MemReadyM,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  StallM,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  FlushM,
  output logic                  FlushW,
  output logic                  MemTimeout,
  output logic [31:0]           PerfStallCnt,
  output logic [31:0]           PerfFlushCnt
);

  localparam int BUSY_W = $clog2(EX_MAX_CYC + 1);

  ctrl_state_t       r_state;
  ctrl_state_t       w_state_nxt;
  logic [15:0]       r_wait_cnt;
  logic [15:0]       w_wait_cnt_inc;
  logic              r_timeout;
  logic [BUSY_W-1:0] r_busy_cnt;

  logic w_load_use;
  logic w_mem_stall;
  logic w_busy;
  logic w_run_eval;
  logic w_start_ok;
  logic w_cnt_inc;
  logic w_timeout_hit;
  logic w_stall_f, w_stall_d, w_stall_e, w_stall_m;
  logic w_flush_d, w_flush_e, w_flush_m, w_flush_w;

  load_use_detect #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_load_use (
    .i_rs1_d      (Rs1D),
    .i_rs2_d      (Rs2D),
    .i_rd_e       (RdE),
    .i_mem_read_e (MemReadE),
    .i_reg_write_e(RegWriteE),
    .o_hazard     (w_load_use)
  );

  // Once in MEM_WAIT only MemReadyM ends the wait; elsewhere a wait needs a request.
  assign w_mem_stall = (r_state == MEM_WAIT) ? ~MemReadyM : (MemReqM & ~MemReadyM);
  // The overlay wait inside EX_BUSY is not a MEM_WAIT cycle and does not count.
  assign w_cnt_inc      = w_mem_stall & (r_state != EX_BUSY);
  assign w_wait_cnt_inc = (r_wait_cnt == '1) ? r_wait_cnt : r_wait_cnt + 16'd1;
  assign w_timeout_hit  = w_cnt_inc & (w_wait_cnt_inc >= 16'(MEM_TIMEOUT));
  assign w_start_ok     = (r_state != EX_BUSY);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_state_nxt;
  end

  // Next state and prioritised stall/flush mux (mem wait > busy > branch > load-use).
  // Exit cycles from MEM_WAIT/EX_BUSY are unstalled, so they are evaluated like RUN
  // to release any branch or load-use that was held behind the stall.
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_run_eval  = 1'b0;
    w_stall_f   = 1'b0;
    w_stall_d   = 1'b0;
    w_stall_e   = 1'b0;
    w_stall_m   = 1'b0;
    w_flush_d   = 1'b0;
    w_flush_e   = 1'b0;
    w_flush_m   = 1'b0;
    w_flush_w   = 1'b0;

    case (r_state)
      RUN: w_run_eval = 1'b1;
      MEM_WAIT: begin
        if (MemReadyM) begin
          w_state_nxt = RUN;
          w_run_eval  = 1'b1;
        end
      end
      EX_BUSY: begin
        if (MultiDoneE) begin
          w_state_nxt = RUN;
          w_run_eval  = 1'b1;
        end else begin
          w_busy = 1'b1;
        end
      end
      default: w_state_nxt = RUN;
    endcase

    if (w_run_eval && w_start_ok) begin
      if (w_mem_stall) begin
        w_state_nxt = MEM_WAIT;
      end else if (MultiStartE && !MultiDoneE) begin
        w_state_nxt = EX_BUSY;
        w_busy      = 1'b1;
      end
    end

    if (w_mem_stall) begin
      w_stall_f = 1'b1;
      w_stall_d = 1'b1;
      w_stall_e = 1'b1;
      w_stall_m = 1'b1;
      w_flush_w = 1'b1;
    end else if (w_busy) begin
      w_stall_f = 1'b1;
      w_stall_d = 1'b1;
      w_stall_e = 1'b1;
      w_flush_m = 1'b1;
    end else if (w_run_eval) begin
      if (PCSrcE) begin
        w_flush_d = 1'b1;
        w_flush_e = 1'b1;
      end else if (w_load_use) begin
        w_stall_f = 1'b1;
        w_stall_d = 1'b1;
        w_flush_e = 1'b1;
      end
    end
  end

  // Wait-cycle counter (saturating) and sticky timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_wait_cnt <= w_cnt_inc ? w_wait_cnt_inc : '0;
      if (w_timeout_hit) r_timeout <= 1'b1;
    end
  end

  // Length of the current multi-cycle op, saturating at EX_MAX_CYC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy_cnt <= '0;
    end else if (r_state == EX_BUSY) begin
      if (r_busy_cnt != BUSY_W'(EX_MAX_CYC)) r_busy_cnt <= r_busy_cnt + 1'b1;
    end else begin
      r_busy_cnt <= '0;
    end
  end

  a_ex_len : assert property (@(posedge clk) disable iff (rst)
    !((r_state == EX_BUSY) && (r_busy_cnt == BUSY_W'(EX_MAX_CYC))));

  // Reset drops every output immediately, independent of the clock.
  assign StallF     = ~rst & w_stall_f;
  assign StallD     = ~rst & w_stall_d;
  assign StallE     = ~rst & w_stall_e;
  assign StallM     = ~rst & w_stall_m;
  assign FlushD     = ~rst & w_flush_d;
  assign FlushE     = ~rst & w_flush_e;
  assign FlushM     = ~rst & w_flush_m;
  assign FlushW     = ~rst & w_flush_w;
  assign MemTimeout = ~rst & (r_timeout | w_timeout_hit);

`ifdef PIPELINE_STALL_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_flush;

  // Free-running (wrapping) stall-cycle and flush-event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_stall <= '0;
      r_perf_flush <= '0;
    end else begin
      if (StallF)           r_perf_stall <= r_perf_stall + 32'd1;
      if (FlushD || FlushE) r_perf_flush <= r_perf_flush + 32'd1;
    end
  end

  assign PerfStallCnt = r_perf_stall;
  assign PerfFlushCnt = r_perf_flush;
`else
  assign PerfStallCnt = '0;
  assign PerfFlushCnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed self-checking bench for pipeline_stall_ctrl (MEM_TIMEOUT=3).
module tb_pipeline_stall_ctrl;

  localparam int RW = 4;
  // Output vector order: {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushM,FlushW}
  localparam logic [7:0] V0 = 8'b0000_0000;
  localparam logic [7:0] LU = 8'b1100_0100;
  localparam logic [7:0] BR = 8'b0000_1100;
  localparam logic [7:0] MW = 8'b1111_0001;
  localparam logic [7:0] BZ = 8'b1110_0010;

  logic          clk = 1'b0;
  logic          rst;
  logic [RW-1:0] Rs1D, Rs2D, RdE;
  logic          MemReadE, RegWriteE, PCSrcE, MultiStartE, MultiDoneE, MemReqM, MemReadyM;
  logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW;
  logic          MemTimeout;
  logic [31:0]   PerfStallCnt, PerfFlushCnt;
  logic [7:0]    outs;

  int checks   = 0;
  int failures = 0;
  int n_stall  = 0;
  int n_flush  = 0;

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(
    .REG_ADDR_W (RW),
    .MEM_TIMEOUT(3),
    .EX_MAX_CYC (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .Rs1D        (Rs1D),
    .Rs2D        (Rs2D),
    .RdE         (RdE),
    .MemReadE    (MemReadE),
    .RegWriteE   (RegWriteE),
    .PCSrcE      (PCSrcE),
    .MultiStartE (MultiStartE),
    .MultiDoneE  (MultiDoneE),
    .MemReqM     (MemReqM),
    .MemReadyM   (MemReadyM),
    .StallF      (StallF),
    .StallD      (StallD),
    .StallE      (StallE),
    .StallM      (StallM),
    .FlushD      (FlushD),
    .FlushE      (FlushE),
    .FlushM      (FlushM),
    .FlushW      (FlushW),
    .MemTimeout  (MemTimeout),
    .PerfStallCnt(PerfStallCnt),
    .PerfFlushCnt(PerfFlushCnt)
  );

  assign outs = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW};

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    Rs1D = '0; Rs2D = '0; RdE = '0;
    MemReadE = 1'b0; RegWriteE = 1'b0; PCSrcE = 1'b0;
    MultiStartE = 1'b0; MultiDoneE = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;
  endtask

  // Inputs are already applied (edge+1); check mid-cycle, then advance one clock.
  task automatic cyc(input string tag, input logic [7:0] ev, input logic to);
    #1;
    chk_eq({tag, ".out"}, 32'(outs), 32'(ev));
    chk_eq({tag, ".to"}, 32'(MemTimeout), 32'(to));
    n_stall += int'(ev[7]);
    n_flush += int'(ev[3] | ev[2]);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_perf(input string tag, input int es, input int ef);
`ifdef PIPELINE_STALL_PERF_EN
    chk_eq({tag, ".pstall"}, PerfStallCnt, 32'(es));
    chk_eq({tag, ".pflush"}, PerfFlushCnt, 32'(ef));
`else
    chk_eq({tag, ".pstall"}, PerfStallCnt, 32'(es) & 32'd0);
    chk_eq({tag, ".pflush"}, PerfFlushCnt, 32'(ef) & 32'd0);
`endif
  endtask

  initial begin
    rst = 1'b1;
    clr();
    @(posedge clk);
    #1;
    chk_eq("reset.out", 32'(outs), 32'(V0));
    chk_eq("reset.to", 32'(MemTimeout), 32'd0);
    chk_perf("reset", 0, 0);
    rst = 1'b0;

    cyc("idle", V0, 1'b0);

    // Load-use on Rs1 and Rs2, then non-hazards.
    MemReadE = 1'b1; RegWriteE = 1'b1; RdE = 4'd3; Rs1D = 4'd3; Rs2D = 4'd5;
    cyc("lu_rs1", LU, 1'b0);
    clr();
    cyc("lu_after", V0, 1'b0);
    MemReadE = 1'b1; RegWriteE = 1'b1; RdE = 4'd7; Rs1D = 4'd1; Rs2D = 4'd7;
    cyc("lu_rs2", LU, 1'b0);
    clr();
    MemReadE = 1'b1; RegWriteE = 1'b1; RdE = 4'd0; Rs1D = 4'd0;
    cyc("lu_x0", V0, 1'b0);
    clr();
    MemReadE = 1'b1; RegWriteE = 1'b0; RdE = 4'd3; Rs1D = 4'd3;
    cyc("lu_nowr", V0, 1'b0);

    // Branch beats a simultaneous load-use.
    RegWriteE = 1'b1; PCSrcE = 1'b1;
    cyc("br_vs_lu", BR, 1'b0);
    clr();
    cyc("br_after", V0, 1'b0);

    // Four wait cycles with a branch held behind them; timeout on the 3rd.
    MemReqM = 1'b1; PCSrcE = 1'b1;
    for (int i = 0; i < 4; i++) cyc($sformatf("memwait%0d", i), MW, (i >= 2));
    MemReadyM = 1'b1;
    cyc("mem_ready_br", BR, 1'b1);
    clr();
    cyc("mem_after", V0, 1'b1);

    // Multi-cycle op, done 5 cycles after start, with a 2-cycle mem wait inside.
    MultiStartE = 1'b1;
    cyc("mc0", BZ, 1'b1);
    MultiStartE = 1'b0;
    cyc("mc1", BZ, 1'b1);
    MemReqM = 1'b1;
    cyc("mc2_mem", MW, 1'b1);
    cyc("mc3_mem", MW, 1'b1);
    MemReqM = 1'b0;
    cyc("mc4", BZ, 1'b1);
    MultiDoneE = 1'b1;
    cyc("mc_done", V0, 1'b1);
    MultiDoneE = 1'b0;
    cyc("mc_after", V0, 1'b1);

    // Stray done is ignored; start+done together is a zero-cycle op.
    MultiDoneE = 1'b1;
    cyc("done_ign", V0, 1'b1);
    MultiDoneE = 1'b0;
    cyc("done_ign2", V0, 1'b1);
    MultiStartE = 1'b1; MultiDoneE = 1'b1;
    cyc("zero_cyc", V0, 1'b1);
    clr();
    cyc("zero_after", V0, 1'b1);

    chk_perf("perf", n_stall, n_flush);

    // Asynchronous reset while busy.
    MultiStartE = 1'b1;
    cyc("rst_mc0", BZ, 1'b1);
    MultiStartE = 1'b0;
    #1;
    chk_eq("rst_mc1.out", 32'(outs), 32'(BZ));
    #1;
    rst = 1'b1;
    #1;
    chk_eq("rst_async.out", 32'(outs), 32'(V0));
    chk_eq("rst_async.to", 32'(MemTimeout), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc("post_rst", V0, 1'b0);
    chk_perf("post_rst", 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
